btn_debouncer: RTL and testbench

//  Upstream conditioning stage for the board push-buttons. Synchronises N raw, asynchronous,

---
 rtl/inout_pkg.sv | 15 +
 rtl/btn_debounce_ch.sv | 96 +++++++++
 rtl/btn_debouncer.sv | 30 +++
 tb/tb_btn_debouncer.sv | 223 ++++++++++++++++++++++
 4 files changed

// File: rtl/inout_pkg.sv
// Shared definitions for the board I/O conditioning blocks.
// Holds the debounce FSM encoding and the default qualification time.
package inout_pkg;

  typedef enum logic [1:0] {
    ST_IDLE         = 2'd0,
    ST_WAIT_PRESS   = 2'd1,
    ST_PRESSED      = 2'd2,
    ST_WAIT_RELEASE = 2'd3
  } deb_state_e;

  // 10 ms of stable input at the 100 MHz board clock
  localparam int unsigned STABLE_CYCLES_DEFAULT = 1_000_000;

endpackage : inout_pkg

// File: rtl/btn_debounce_ch.sv
// One debounce channel: 2-FF synchroniser, stability counter, qualification FSM
// and registered single-cycle press/release pulses.
module btn_debounce_ch
  import inout_pkg::*;
#(
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic reset,
  input  logic btn_raw,
  output logic btn_level,
  output logic btn_press,
  output logic btn_release
);

  localparam int unsigned CNT_W = $clog2(STABLE_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(STABLE_CYCLES - 1);

  logic             s1_q, s2_q;
  deb_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             release_q, release_d;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      s1_q      <= 1'b0;
      s2_q      <= 1'b0;
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      level_q   <= 1'b0;
      press_q   <= 1'b0;
      release_q <= 1'b0;
    end else begin
      s1_q      <= btn_raw;
      s2_q      <= s1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      level_q   <= level_d;
      press_q   <= press_d;
      release_q <= release_d;
    end
  end

  // Pulses default low so each one lasts exactly one cycle
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    level_d   = level_q;
    press_d   = 1'b0;
    release_d = 1'b0;
    unique case (state_q)
      ST_IDLE: begin
        if (s2_q) begin
          state_d = ST_WAIT_PRESS;
          cnt_d   = '0;
        end
      end
      ST_WAIT_PRESS: begin
        if (!s2_q) begin
          state_d = ST_IDLE;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_PRESSED;
          level_d = 1'b1;
          press_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_PRESSED: begin
        if (!s2_q) begin
          state_d = ST_WAIT_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_WAIT_RELEASE: begin
        if (s2_q) begin
          state_d = ST_PRESSED;
        end else if (cnt_q == CNT_LAST) begin
          state_d   = ST_IDLE;
          level_d   = 1'b0;
          release_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign btn_level   = level_q;
  assign btn_press   = press_q;
  assign btn_release = release_q;

endmodule : btn_debounce_ch

// File: rtl/btn_debouncer.sv
// Push-button conditioning: N_BTNS independent debounce channels side by side.
// Channels share only clock and reset; there is no arbitration between them.
module btn_debouncer
  import inout_pkg::*;
#(
  parameter int unsigned N_BTNS        = 5,
  parameter int unsigned STABLE_CYCLES = STABLE_CYCLES_DEFAULT
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [N_BTNS-1:0] btn_raw,
  output logic [N_BTNS-1:0] btn_level,
  output logic [N_BTNS-1:0] btn_press,
  output logic [N_BTNS-1:0] btn_release
);

  for (genvar i = 0; i < N_BTNS; i++) begin : g_ch
    btn_debounce_ch #(
      .STABLE_CYCLES(STABLE_CYCLES)
    ) u_ch (
      .clk        (clk),
      .reset      (reset),
      .btn_raw    (btn_raw[i]),
      .btn_level  (btn_level[i]),
      .btn_press  (btn_press[i]),
      .btn_release(btn_release[i])
    );
  end

endmodule : btn_debouncer

// File: tb/tb_btn_debouncer.sv
// Directed bench for btn_debouncer with STABLE_CYCLES=4: a held input
// qualifies on the 7th clock edge after it changes.
module tb_btn_debouncer;

  localparam int N = 5;

  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] btn_raw;
  logic [N-1:0] btn_level, btn_press, btn_release;

  int nvec = 0;
  int nerr = 0;

  btn_debouncer #(.N_BTNS(N), .STABLE_CYCLES(4)) dut (
    .clk        (clk),
    .reset      (reset),
    .btn_raw    (btn_raw),
    .btn_level  (btn_level),
    .btn_press  (btn_press),
    .btn_release(btn_release)
  );

  always #5 clk = ~clk;

  // Advance one rising edge; inputs change and outputs are sampled 1 time unit later
  task automatic tick(input int n = 1);
    for (int k = 0; k < n; k++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_reset;
    reset   = 1'b0;
    btn_raw = 5'b11111;
    tick(3);
    nvec++;
    if ({btn_level, btn_press, btn_release} !== 15'd0) begin
      nerr++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b, want all 0", btn_level, btn_press, btn_release);
    end
    reset = 1'b1;
    tick(6);
    nvec++;
    if (btn_press !== 5'b00000 || btn_level !== 5'b00000) begin
      nerr++;
      $display("FAIL all_edge6: got prs=%b lvl=%b, want 00000/00000", btn_press, btn_level);
    end
    tick(1);
    nvec++;
    if (btn_press !== 5'b11111 || btn_level !== 5'b11111) begin
      nerr++;
      $display("FAIL all_edge7: got prs=%b lvl=%b, want 11111/11111", btn_press, btn_level);
    end
    tick(1);
    nvec++;
    if (btn_press !== 5'b00000 || btn_level !== 5'b11111) begin
      nerr++;
      $display("FAIL all_edge8: got prs=%b lvl=%b, want 00000/11111", btn_press, btn_level);
    end
    btn_raw = 5'b00000;
    tick(7);
    nvec++;
    if (btn_release !== 5'b11111 || btn_level !== 5'b00000) begin
      nerr++;
      $display("FAIL all_release: got rel=%b lvl=%b, want 11111/00000", btn_release, btn_level);
    end
    tick(3);
  endtask

  task automatic test_single_press;
    int pulses = 0;
    btn_raw[0] = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (btn_press[0]) pulses++;
      if (c == 7) begin
        nvec++;
        if (btn_press !== 5'b00001 || btn_level !== 5'b00001) begin
          nerr++;
          $display("FAIL press0_edge7: got prs=%b lvl=%b, want 00001/00001", btn_press, btn_level);
        end
      end
    end
    nvec++;
    if (pulses !== 1 || btn_level[0] !== 1'b1) begin
      nerr++;
      $display("FAIL press0_once: got %0d pulses lvl=%b, want 1 pulse lvl=1", pulses, btn_level[0]);
    end
    btn_raw[0] = 1'b0;
    tick(10);
    nvec++;
    if (btn_level !== 5'b00000) begin
      nerr++;
      $display("FAIL press0_back_idle: got lvl=%b, want 00000", btn_level);
    end
  endtask

  task automatic test_bounce;
    int bad = 0;
    for (int c = 0; c < 16; c++) begin
      btn_raw[1] = ((c / 2) % 2 == 0);
      tick(1);
      if (btn_press[1] || btn_release[1] || btn_level[1]) bad++;
    end
    btn_raw[1] = 1'b0;
    for (int c = 0; c < 10; c++) begin
      tick(1);
      if (btn_press[1] || btn_release[1] || btn_level[1]) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL bounce1: got %0d cycles with activity, want 0", bad);
    end
  endtask

  task automatic test_release;
    btn_raw[2] = 1'b1;
    tick(10);
    nvec++;
    if (btn_level !== 5'b00100) begin
      nerr++;
      $display("FAIL rel2_pressed: got lvl=%b, want 00100", btn_level);
    end
    btn_raw[2] = 1'b0;
    tick(6);
    nvec++;
    if (btn_level !== 5'b00100 || btn_release !== 5'b00000) begin
      nerr++;
      $display("FAIL rel2_edge6: got lvl=%b rel=%b, want 00100/00000", btn_level, btn_release);
    end
    tick(1);
    nvec++;
    if (btn_level !== 5'b00000 || btn_release !== 5'b00100) begin
      nerr++;
      $display("FAIL rel2_edge7: got lvl=%b rel=%b, want 00000/00100", btn_level, btn_release);
    end
    tick(1);
    nvec++;
    if (btn_release !== 5'b00000) begin
      nerr++;
      $display("FAIL rel2_edge8: got rel=%b, want 00000", btn_release);
    end
    tick(3);
  endtask

  task automatic test_short_pulse;
    int bad = 0;
    btn_raw[3] = 1'b1;
    tick(3);
    btn_raw[3] = 1'b0;
    for (int c = 0; c < 12; c++) begin
      tick(1);
      if (btn_press[3] || btn_release[3] || btn_level[3]) bad++;
    end
    nvec++;
    if (bad !== 0) begin
      nerr++;
      $display("FAIL short3: got %0d cycles with activity, want 0", bad);
    end
    // A fresh press must take the full qualification time from IDLE
    btn_raw[3] = 1'b1;
    tick(7);
    nvec++;
    if (btn_press !== 5'b01000) begin
      nerr++;
      $display("FAIL short3_requal: got prs=%b, want 01000", btn_press);
    end
    btn_raw[3] = 1'b0;
    tick(10);
  endtask

  task automatic test_reset_midqual;
    btn_raw[2] = 1'b1;
    tick(10);
    btn_raw[4] = 1'b1;
    tick(5);
    #2;
    reset = 1'b0;
    #1;
    nvec++;
    if ({btn_level, btn_press, btn_release} !== 15'd0) begin
      nerr++;
      $display("FAIL midreset_async: got lvl=%b prs=%b rel=%b, want all 0", btn_level, btn_press, btn_release);
    end
    tick(2);
    reset = 1'b1;
    tick(6);
    nvec++;
    if (btn_press !== 5'b00000 || btn_level !== 5'b00000) begin
      nerr++;
      $display("FAIL midreset_edge6: got prs=%b lvl=%b, want 00000/00000", btn_press, btn_level);
    end
    tick(1);
    nvec++;
    if (btn_press !== 5'b10100 || btn_level !== 5'b10100) begin
      nerr++;
      $display("FAIL midreset_edge7: got prs=%b lvl=%b, want 10100/10100", btn_press, btn_level);
    end
    tick(1);
    nvec++;
    if (btn_press !== 5'b00000 || btn_release !== 5'b00000) begin
      nerr++;
      $display("FAIL midreset_edge8: got prs=%b rel=%b, want 00000/00000", btn_press, btn_release);
    end
  endtask

  initial begin
    reset   = 1'b0;
    btn_raw = '0;
    test_reset();
    test_single_press();
    test_bounce();
    test_release();
    test_short_pulse();
    test_reset_midqual();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule : tb_btn_debouncer
